// File: rtl/clock_set_ctrl_if.sv
// Button inputs and counter-control / display outputs of the clock set controller.
interface clock_set_ctrl_if;
  logic       btn_mode_n;
  logic       btn_inc_n;
  logic       sec_en;
  logic       sec_clr;
  logic       min_inc;
  logic       hour_inc;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_mode_n, btn_inc_n,
    input  sec_en, sec_clr, min_inc, hour_inc, mode, blink
  );

  modport slave (
    input  btn_mode_n, btn_inc_n,
    output sec_en, sec_clr, min_inc, hour_inc, mode, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Timekeeping sequencer: 1 Hz prescaler, debounced buttons, and set-mode FSM
// that pulses the cascaded BCD time counters and drives the display blink gate.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEB_CYCLES);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_SET_HOUR = 2'd1,
    S_SET_MIN  = 2'd2,
    S_SET_SEC  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_pre;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_sec_en;
  logic          r_sec_clr;
  logic          r_min_inc;
  logic          r_hour_inc;
  logic          w_tick;
  logic          w_sec_en_nxt;
  logic          w_sec_clr_nxt;
  logic          w_min_inc_nxt;
  logic          w_hour_inc_nxt;
  logic [1:0]    w_raw;
  logic [1:0]    w_ev;
  logic          w_mode_ev;
  logic          w_inc_ev;

  assign w_raw     = {bus.btn_inc_n, bus.btn_mode_n};
  assign w_mode_ev = w_ev[0];
  assign w_inc_ev  = w_ev[1];

  // Per button: 2-FF sync, stability counter, one-cycle pulse on accepted press
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic          r_s1;
    logic          r_s2;
    logic          r_acc;
    logic          r_ev;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_acc <= 1'b1;
        r_ev  <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[g];
        r_s2 <= r_s1;
        r_ev <= 1'b0;
        if (r_s2 != r_acc) begin
          if (r_cnt == DW'(DEB_CYCLES - 1)) begin
            r_acc <= r_s2;
            r_cnt <= '0;
            r_ev  <= ~r_s2;
          end else begin
            r_cnt <= r_cnt + DW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    assign w_ev[g] = r_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next state and next pulse values; a mode event always beats an inc event
  always_comb begin
    w_state_nxt    = r_state;
    w_tick         = 1'b0;
    w_sec_en_nxt   = 1'b0;
    w_sec_clr_nxt  = 1'b0;
    w_min_inc_nxt  = 1'b0;
    w_hour_inc_nxt = 1'b0;

    if (r_state == S_RUN && r_pre == TW'(TICK_DIV - 1)) w_tick = 1'b1;
    w_sec_en_nxt = w_tick;

    if (w_mode_ev) begin
      unique case (r_state)
        S_RUN:      w_state_nxt = S_SET_HOUR;
        S_SET_HOUR: w_state_nxt = S_SET_MIN;
        S_SET_MIN:  w_state_nxt = S_SET_SEC;
        S_SET_SEC:  w_state_nxt = S_RUN;
      endcase
    end else if (w_inc_ev) begin
      case (r_state)
        S_SET_HOUR: w_hour_inc_nxt = 1'b1;
        S_SET_MIN:  w_min_inc_nxt  = 1'b1;
        S_SET_SEC:  w_sec_clr_nxt  = 1'b1;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sec_en   <= 1'b0;
      r_sec_clr  <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hour_inc <= 1'b0;
    end else begin
      r_sec_en   <= w_sec_en_nxt;
      r_sec_clr  <= w_sec_clr_nxt;
      r_min_inc  <= w_min_inc_nxt;
      r_hour_inc <= w_hour_inc_nxt;
    end
  end

  // Prescaler restarts from 0 on every entry into RUN so the first tick is a full period later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (r_state != S_RUN || w_state_nxt != S_RUN || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (w_state_nxt != r_state || r_state == S_RUN) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign bus.sec_en   = r_sec_en;
  assign bus.sec_clr  = r_sec_clr;
  assign bus.min_inc  = r_min_inc;
  assign bus.hour_inc = r_hour_inc;
  assign bus.mode     = r_state;
  assign bus.blink    = r_blink;

endmodule
